// File: rtl/lsu_split.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_split
//  Description : Registered, handshaked load/store unit. Misaligned accesses
//                optionally split into two aligned word transactions.
//  Revision    : 1.0
// ============================================================================

`ifndef DATA_BYTE
`define DATA_BYTE 2'b00
`endif
`ifndef DATA_HALF_WORD
`define DATA_HALF_WORD 2'b01
`endif
`ifndef DATA_WORD
`define DATA_WORD 2'b10
`endif

module lsu_split #(
    parameter int ADDR_WIDTH       = 32,
    parameter int MEM_ADDR_BITS    = 20,
    parameter bit MISALIGNED_SPLIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            type_i,
    input  logic                  sign_extend_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  resp_valid_o,
    output logic                  resp_err_o,
    output logic [31:0]           rdata_o,
    output logic                  dmem_valid_o,
    input  logic                  dmem_ready_i,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    output logic [3:0]            dmem_we_o,
    input  logic [31:0]           dmem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ0 = 2'd1,
        S_REQ1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic                  r_sext;
    logic                  r_split;
    logic                  r_err;
    logic [1:0]            r_off;
    logic [2:0]            r_nbytes;
    logic [ADDR_WIDTH-3:0] r_word;
    logic [7:0]            r_mask;
    logic [63:0]           r_data;
    logic [63:0]           r_buf;

    logic                  w_type_ok;
    logic [2:0]            w_nbytes;
    logic [1:0]            w_nm1;
    logic [3:0]            w_mask4;
    logic [7:0]            w_mask8;
    logic [63:0]           w_data64;
    logic                  w_split;
    logic                  w_misalign;
    logic [ADDR_WIDTH:0]   w_incr;
    logic [ADDR_WIDTH:0]   w_last;
    logic                  w_oob;
    logic                  w_err;

    // Request decode, evaluated on the accept edge only
    always_comb begin
        w_type_ok = 1'b1;
        w_nbytes  = 3'd1;
        w_mask4   = 4'b0001;
        case (type_i)
            `DATA_BYTE:      begin w_nbytes = 3'd1; w_mask4 = 4'b0001; end
            `DATA_HALF_WORD: begin w_nbytes = 3'd2; w_mask4 = 4'b0011; end
            `DATA_WORD:      begin w_nbytes = 3'd4; w_mask4 = 4'b1111; end
            default:         w_type_ok = 1'b0;
        endcase
        w_nm1      = w_nbytes[1:0] - 2'd1;
        w_mask8    = {4'b0000, w_mask4} << addr_i[1:0];
        w_data64   = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
        w_split    = |w_mask8[7:4];
        w_misalign = ((w_nbytes == 3'd2) & addr_i[0]) |
                     ((w_nbytes == 3'd4) & (|addr_i[1:0]));
        w_incr      = '0;
        w_incr[1:0] = w_nm1;
        w_last      = {1'b0, addr_i} + w_incr;
        // A carry out of the last-byte address is treated as out of range too
        w_oob = (|(addr_i >> MEM_ADDR_BITS)) |
                (w_split & ((|(w_last >> MEM_ADDR_BITS)) | w_last[ADDR_WIDTH]));
        w_err = ~w_type_ok | w_oob |
                ((MISALIGNED_SPLIT == 1'b0) & (w_misalign | w_split));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_sext   <= 1'b0;
            r_split  <= 1'b0;
            r_err    <= 1'b0;
            r_off    <= 2'b00;
            r_nbytes <= 3'd0;
            r_word   <= '0;
            r_mask   <= 8'h00;
            r_data   <= 64'h0;
            r_buf    <= 64'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we     <= req_we_i;
                        r_sext   <= sign_extend_i;
                        r_split  <= w_split;
                        r_err    <= w_err;
                        r_off    <= addr_i[1:0];
                        r_nbytes <= w_nbytes;
                        r_word   <= addr_i[ADDR_WIDTH-1:2];
                        r_mask   <= w_mask8;
                        r_data   <= w_data64;
                        r_buf    <= 64'h0;
                        r_state  <= w_err ? S_RESP : S_REQ0;
                    end
                end
                S_REQ0: begin
                    if (dmem_ready_i) begin
                        r_buf[31:0] <= dmem_rdata_i;
                        r_state     <= r_split ? S_REQ1 : S_RESP;
                    end
                end
                S_REQ1: begin
                    if (dmem_ready_i) begin
                        r_buf[63:32] <= dmem_rdata_i;
                        r_state      <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic                  w_active;
    logic                  w_hi;
    logic                  w_store_active;
    logic [3:0]            w_lane_we;
    logic [31:0]           w_word_data;
    logic [ADDR_WIDTH-3:0] w_word_inc;
    logic                  w_resp;
    logic [31:0]           w_sel;
    logic [31:0]           w_ext;

    always_comb begin
        w_active       = rst_n & ((r_state == S_REQ0) | (r_state == S_REQ1));
        w_hi           = (r_state == S_REQ1);
        w_store_active = w_active & r_we;
        w_lane_we      = w_store_active ? (w_hi ? r_mask[7:4] : r_mask[3:0]) : 4'b0000;
        w_word_data    = w_hi ? r_data[63:32] : r_data[31:0];
        w_word_inc     = '0;
        w_word_inc[0]  = w_hi;
        w_resp         = rst_n & (r_state == S_RESP);

        // Load data right-aligned from the merged two-word buffer
        w_sel = r_buf[{r_off, 3'b000} +: 32];
        case (r_nbytes)
            3'd1:    w_ext = {{24{r_sext & w_sel[7]}}, w_sel[7:0]};
            3'd2:    w_ext = {{16{r_sext & w_sel[15]}}, w_sel[15:0]};
            default: w_ext = w_sel;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign dmem_wdata_o[8*gi +: 8] = w_lane_we[gi] ? w_word_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign req_ready_o  = rst_n & (r_state == S_IDLE);
    assign dmem_valid_o = w_active;
    assign dmem_addr_o  = w_active ? {r_word + w_word_inc, 2'b00} : '0;
    assign dmem_we_o    = w_lane_we;
    assign resp_valid_o = w_resp;
    assign resp_err_o   = w_resp & r_err;
    assign rdata_o      = (w_resp & ~r_err & ~r_we) ? w_ext : 32'h0;

endmodule

`default_nettype wire
